legv8_data_memory_unit: RTL
===========================

// Module: legv8_data_memory_unit
// PURPOSE
//  Parametrised, size-aware data memory for the LEGv8 datapath. Replaces the fixed single-cycle RAM.
//  Serves byte/half/word/dword loads and stores on the shared tri-state data bus.
//  Access latency is programmable. A ready/done handshake lets the control-word sequencer stall.
//  Misaligned or out-of-range accesses raise a fault and never modify memory.
// PARAMETERS
//  DATA_WIDTH  64  data bus width in bits; must be 64 (dword access assumed)
//  ADDR_WIDTH  32  byte-address width
//  DEPTH       256 number of DATA_WIDTH-bit words in the array
//  LATENCY     2   wait cycles between request accept and completion; >=1
// PORTS
//  clock      in     1           rising-edge clock
//  reset      in     1           asynchronous, active-low reset
//  address    in     ADDR_WIDTH  byte address, sampled on accept
//  mem_read   in     1           load request
//  mem_write  in     1           store request
//  size       in     2           00 byte, 01 half, 10 word, 11 dword
//  sign_ext   in     1           loads: 1 = sign-extend, 0 = zero-extend
//  data       inout  DATA_WIDTH  store data in; load data out; Z when not driving
//  ready      out    1           1 = idle, request can be accepted this cycle
//  done       out    1           one-cycle pulse: access completed
//  fault      out    1           one-cycle pulse: access rejected
// BEHAVIOUR
//  Reset (async, reset=0):
//   - FSM to IDLE; ready=1, done=0, fault=0; data bus released (Z); wait counter=0.
//   - Array contents NOT cleared.
//  Accept: in IDLE, a request with exactly one of mem_read/mem_write =1 is accepted at the clock edge.
//   - address, size and sign_ext are latched.
//   - Store data is latched from data in the same edge.
//   - ready drops the next cycle.
//  Illegal request, checked at accept:
//   - both mem_read and mem_write =1;
//   - address not a multiple of (1<<size);
//   - word index address>>3 >= DEPTH.
//   - Response: go to FAULT for 1 cycle; fault=1, done=0; no array write; then IDLE.
//  FSM states:
//   - IDLE -> WAIT (legal request) | FAULT (illegal request)
//   - WAIT: counter counts 1..LATENCY, then -> DONE
//   - DONE -> IDLE
//   - FAULT -> IDLE
//  Timing: accept edge at cycle T; done=1 during cycle T+LATENCY+1; ready=1 again at T+LATENCY+2.
//  Store: the array word is updated on the edge leaving WAIT.
//   - Read-modify-write of the 64-bit word.
//   - Only lanes [8*(a%8) +: 8<<size] change; little-endian.
//  Load:
//   - During DONE, data drives the selected lane, right-justified.
//   - Upper bits = sign bit of the lane if sign_ext, else 0.
//   - The bus is driven in DONE only; Z in every other state and whenever write is set.
//  Idle inputs: mem_read/mem_write held high outside IDLE are ignored, not queued.
//   - A request still high when back in IDLE is a new request.
//  Reset mid-access: the access is abandoned.
//   - A store not yet committed leaves the array unchanged.
//   - The bus is released immediately.
//  Address arithmetic: bits above log2(DEPTH)+3 take part in the range check only; no wrap-around.
// STRUCTURE
//  Shared package legv8_mem_pkg:
//   - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
//   - FSM state encoding (IDLE, WAIT, DONE, FAULT).
//  Sub-module legv8_lane_align (combinational):
//   - store: merges the lane into the old word under a byte mask;
//   - load: extracts the lane and extends it.
//  The FSM, counter, array and tri-state driver stay in this module.
// TESTING
//  - Reset, then idle: ready=1, done=0, fault=0, data=Z, held for 10 cycles with no request.
//  - Store dword 64'hFFFF_FFFF_FFFF_FFE8 at addr 24, then load dword at 24.
//    Required: done at accept+LATENCY+1 both times; load returns same value; ready low for LATENCY+2 cycles.
//  - Store byte 8'h80 at addr 25 over 64'h0, then loads at 24:
//    dword reads 64'h8000;
//    byte at 25 with sign_ext=1 reads 64'hFFFF_FFFF_FFFF_FF80;
//    byte at 25 with sign_ext=0 reads 64'h80.
//  - Misaligned word store at addr 26, then out-of-range load at DEPTH*8.
//    Required: fault pulse 1 cycle after accept, no done, memory at 24 unchanged.
//    Same for mem_read=mem_write=1.
//  - Reset asserted while a store to addr 32 is in WAIT: bus Z at once, ready=1 after release, addr 32 keeps old value.
//  - Re-run for LATENCY=1 and LATENCY=4 with DEPTH=16: completion cycle tracks LATENCY; addr 120 legal, addr 128 faults.

Source files
------------

// File: rtl/legv8_mem_pkg.sv
// Shared encodings for the LEGv8 data memory: access sizes, FSM states and the
// alignment mask helper used by the request legality check.
package legv8_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone,
        StFault
    } mem_state_e;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input mem_size_e sz);
        case (sz)
            SZ_BYTE: return 3'b000;
            SZ_HALF: return 3'b001;
            SZ_WORD: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/legv8_lane_align.sv
// Little-endian lane steering: merges a store lane into the old word under a
// byte mask, and extracts/extends a load lane right-justified.
module legv8_lane_align
    import legv8_mem_pkg::*;
(
    input  logic [63:0] old_word,
    input  logic [63:0] store_data,
    input  logic [2:0]  offset,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [63:0] merged_word,
    output logic [63:0] load_data
);

    logic [7:0]  base_mask;
    logic [7:0]  byte_mask;
    logic [63:0] wshift;
    logic [63:0] rshift;

    always_comb begin
        case (size)
            SZ_BYTE: base_mask = 8'h01;
            SZ_HALF: base_mask = 8'h03;
            SZ_WORD: base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        byte_mask = base_mask << offset;
        wshift    = store_data << {offset, 3'b000};
        rshift    = old_word >> {offset, 3'b000};

        merged_word = old_word;
        for (int i = 0; i < 8; i++) begin
            if (byte_mask[i]) begin
                merged_word[8*i +: 8] = wshift[8*i +: 8];
            end
        end

        case (size)
            SZ_BYTE: load_data = {{56{sign_ext & rshift[7]}},  rshift[7:0]};
            SZ_HALF: load_data = {{48{sign_ext & rshift[15]}}, rshift[15:0]};
            SZ_WORD: load_data = {{32{sign_ext & rshift[31]}}, rshift[31:0]};
            default: load_data = rshift;
        endcase
    end

endmodule

// File: rtl/legv8_data_memory_unit.sv
// Size-aware LEGv8 data memory with programmable latency, ready/done handshake
// and fault reporting for misaligned or out-of-range requests.
module legv8_data_memory_unit
    import legv8_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  done,
    output logic                  fault
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [2:0]            off_q;
    mem_size_e             size_q;
    logic                  sext_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    mem_size_e             req_size;
    logic                  accept;
    logic                  illegal;
    logic                  commit;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_size = mem_size_e'(size);

    // Full address takes part in the range check, so high bits never wrap.
    assign illegal = (mem_read & mem_write)
                   | (|(address[2:0] & align_mask(req_size)))
                   | ((address >> 3) >= ADDR_WIDTH'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_read | mem_write) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = illegal ? StFault : StWait;
                end
            end
            StWait: begin
                if (cnt_q == CNT_W'(LATENCY)) begin
                    commit  = wr_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= address[3 +: IDX_W];
                off_q   <= address[2:0];
                size_q  <= req_size;
                sext_q  <= sign_ext;
                wr_q    <= mem_write;
                wdata_q <= data;
            end
        end
    end

    // Array is deliberately not reset; a reset during WAIT suppresses commit.
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[idx_q] <= merged_word;
        end
    end

    assign old_word = mem[idx_q];

    legv8_lane_align u_lane_align (
        .old_word    (old_word),
        .store_data  (wdata_q),
        .offset      (off_q),
        .size        (size_q),
        .sign_ext    (sext_q),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign fault = (state_q == StFault);
    assign data  = (state_q == StDone && !wr_q) ? load_data : {DATA_WIDTH{1'bz}};

endmodule
